// File: rtl/alu_unit_if.sv
// Issue/result bus between the reservation station and the integer ALU.
// The issuing side is master; the ALU is slave and drives the result fields.
interface alu_unit_if #(
    parameter int ROB_ADDR = 4,
    parameter int OP_W     = 6
);
    logic [OP_W-1:0]     alu_op;
    logic [31:0]         alu_rs1;
    logic [31:0]         alu_rs2;
    logic [ROB_ADDR-1:0] alu_id;
    logic                alu_valid;
    logic [ROB_ADDR-1:0] alu_robid;
    logic [31:0]         alu_val;
    logic                alu_is_br;
    logic [31:0]         alu_cnt;

    modport master (
        output alu_op, alu_rs1, alu_rs2, alu_id,
        input  alu_valid, alu_robid, alu_val, alu_is_br, alu_cnt
    );

    modport slave (
        input  alu_op, alu_rs1, alu_rs2, alu_id,
        output alu_valid, alu_robid, alu_val, alu_is_br, alu_cnt
    );
endinterface

// File: rtl/alu_unit.sv
// RV32I integer / branch-compare execution unit with a single registered
// result stage broadcast on the ALU result bus.
module alu_unit #(
    parameter int ROB_ADDR = 4,
    parameter int OP_W     = 6
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       rdy_in,
    input  logic       clear_in,
    alu_unit_if.slave  bus
);
    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_SUB  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_SLL  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_SLT  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_SLTU = OP_W'(5);
    localparam logic [OP_W-1:0] OP_XOR  = OP_W'(6);
    localparam logic [OP_W-1:0] OP_SRL  = OP_W'(7);
    localparam logic [OP_W-1:0] OP_SRA  = OP_W'(8);
    localparam logic [OP_W-1:0] OP_OR   = OP_W'(9);
    localparam logic [OP_W-1:0] OP_AND  = OP_W'(10);
    localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(11);
    localparam logic [OP_W-1:0] OP_BNE  = OP_W'(12);
    localparam logic [OP_W-1:0] OP_BLT  = OP_W'(13);
    localparam logic [OP_W-1:0] OP_BGE  = OP_W'(14);
    localparam logic [OP_W-1:0] OP_BLTU = OP_W'(15);
    localparam logic [OP_W-1:0] OP_BGEU = OP_W'(16);

    logic [31:0]         res_val_s;
    logic                res_br_s;
    logic                res_legal_s;
    logic                lt_s;
    logic                ltu_s;
    logic [4:0]          shamt_s;

    logic                valid_r;
    logic [ROB_ADDR-1:0] robid_r;
    logic [31:0]         val_r;
    logic                is_br_r;
    logic [31:0]         cnt_r;

    // Branch compares reuse the SLT/SLTU comparators; taken is reported in bit 0.
    function automatic logic [31:0] taken_word(input logic taken);
        return {31'd0, taken};
    endfunction

    // Decode the opcode and compute the combinational result for this cycle.
    always_comb begin
        res_val_s   = 32'd0;
        res_br_s    = 1'b0;
        res_legal_s = 1'b1;
        shamt_s     = bus.alu_rs2[4:0];
        lt_s        = ($signed(bus.alu_rs1) < $signed(bus.alu_rs2));
        ltu_s       = (bus.alu_rs1 < bus.alu_rs2);
        case (bus.alu_op)
            OP_ADD:  res_val_s = bus.alu_rs1 + bus.alu_rs2;
            OP_SUB:  res_val_s = bus.alu_rs1 - bus.alu_rs2;
            OP_SLL:  res_val_s = bus.alu_rs1 << shamt_s;
            OP_SLT:  res_val_s = taken_word(lt_s);
            OP_SLTU: res_val_s = taken_word(ltu_s);
            OP_XOR:  res_val_s = bus.alu_rs1 ^ bus.alu_rs2;
            OP_SRL:  res_val_s = bus.alu_rs1 >> shamt_s;
            OP_SRA:  res_val_s = $unsigned($signed(bus.alu_rs1) >>> shamt_s);
            OP_OR:   res_val_s = bus.alu_rs1 | bus.alu_rs2;
            OP_AND:  res_val_s = bus.alu_rs1 & bus.alu_rs2;
            OP_BEQ: begin
                res_val_s = taken_word(bus.alu_rs1 == bus.alu_rs2);
                res_br_s  = 1'b1;
            end
            OP_BNE: begin
                res_val_s = taken_word(bus.alu_rs1 != bus.alu_rs2);
                res_br_s  = 1'b1;
            end
            OP_BLT: begin
                res_val_s = taken_word(lt_s);
                res_br_s  = 1'b1;
            end
            OP_BGE: begin
                res_val_s = taken_word(!lt_s);
                res_br_s  = 1'b1;
            end
            OP_BLTU: begin
                res_val_s = taken_word(ltu_s);
                res_br_s  = 1'b1;
            end
            OP_BGEU: begin
                res_val_s = taken_word(!ltu_s);
                res_br_s  = 1'b1;
            end
            default: res_legal_s = 1'b0;
        endcase
    end

    // Result register: flush beats issue, bubbles and illegal ops clear the bus.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            valid_r <= 1'b0;
            robid_r <= '0;
            val_r   <= 32'd0;
            is_br_r <= 1'b0;
            cnt_r   <= 32'd0;
        end else if (rdy_in) begin
            if (clear_in || !res_legal_s) begin
                valid_r <= 1'b0;
                robid_r <= '0;
                val_r   <= 32'd0;
                is_br_r <= 1'b0;
            end else begin
                valid_r <= 1'b1;
                robid_r <= bus.alu_id;
                val_r   <= res_val_s;
                is_br_r <= res_br_s;
                cnt_r   <= cnt_r + 32'd1;
            end
        end
    end

    assign bus.alu_valid = valid_r;
    assign bus.alu_robid = robid_r;
    assign bus.alu_val   = val_r;
    assign bus.alu_is_br = is_br_r;
    assign bus.alu_cnt   = cnt_r;
endmodule
